cu_pipe_ctrl: RTL and testbench
===============================

CU_PIPE_CTRL -- requirements
Module: cu_pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all flops rising-edge.
REQ-002 SHALL have port R, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port instruction, input, 32 bits: ARM-style instruction from IF/ID.
REQ-004 SHALL have port S, input, 1 bit: bubble select; 1 forces all ID-stage controls to 0.
REQ-005 SHALL have ID-stage outputs (combinational, after mux): ID_opcode[3:0], ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr.
REQ-006 SHALL have EX-stage registered outputs: EX_opcode[3:0], EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable, EX_RW_enable, EX_Enable_signal.
REQ-007 SHALL have MEM-stage registered outputs: MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal.

Function
REQ-008 Decoder SHALL be purely combinational; condition field [31:28] ignored.
REQ-009 Data processing ([27:26]=00, excluding [27:25]=000 with [7]=1 and [4]=1): opcode=[24:21], S_enable=[20], AM=[25] (1 = immediate operand), RF_enable=1 except opcodes 1000-1011 (TST/TEQ/CMP/CMN) -> 0; memory and branch controls 0.
REQ-010 Load/store ([27:26]=01): Enable_signal=1, load_instr=[20], RF_enable=[20], RW_enable=~[20] (1 = write), Size_enable=[22] (1 = byte), opcode=0100 if U=[23]=1 else 0010, AM=~[25] (1 = immediate offset), S_enable=0, branch flags 0.
REQ-011 Branch ([27:25]=101): B_instr=1, BL_instr=[24], RF_enable=[24] (link write), opcode=0000, all other controls 0.
REQ-012 All other encodings, including the excluded multiply/extra-load space, SHALL decode to all-zero controls.
REQ-013 Instruction 0x00000000 SHALL decode to all-zero controls (NOP).
REQ-014 Mux: S=0 passes decoder outputs to ID_*; S=1 drives every ID_* to 0 in the same cycle.
REQ-015 ID/EX register: on each rising clk, EX_* SHALL load the corresponding ID_*; latency 1 cycle. ID_BL_instr and ID_B_instr are not propagated.
REQ-016 EX/MEM register: on each rising clk, MEM_* SHALL load the corresponding EX_*; latency 2 cycles from ID.
REQ-017 No enable/stall on the stage registers; they update every cycle.

Reset
REQ-018 R=0 SHALL asynchronously clear every EX_*, MEM_* (and WB_*) flop to 0, independent of clk.
REQ-019 ID_* outputs SHALL NOT be affected by R; they follow instruction and S.
REQ-020 After R returns to 1, the first rising clk SHALL capture the current ID_* values.

Configuration
REQ-021 Macro CU_PIPE_WB_STAGE_EN defined: add output WB_RF_enable (1 bit), registered from MEM_RF_enable each rising clk, async-cleared by R; latency 3 cycles from ID.
REQ-022 Macro CU_PIPE_WB_STAGE_EN undefined: no WB_RF_enable port and no WB flop.

Verification
REQ-023 instruction=0xE2921005, S=0 -> ID_opcode=0100, ID_S_enable=1, ID_AM=1, ID_RF_enable=1, other ID_* 0; after 1 edge EX_* match; after 2 edges MEM_RF_enable=1.
REQ-024 instruction=0xE5910004 (LDR) -> load=1, RF=1, Enable=1, RW=0, Size=0, opcode=0100, AM=1; instruction=0xE5410001 (STRB, U=0) -> RW=1, Size=1, Enable=1, RF=0, load=0, opcode=0010.
REQ-025 instruction=0xEB000004 (BL) -> ID_B_instr=1, ID_BL_instr=1, ID_RF_enable=1, opcode=0000; 0xEA000004 (B) -> B_instr=1, BL_instr=0, RF_enable=0; 0xE3510000 (CMP) -> opcode=1010, S_enable=1, RF_enable=0.
REQ-026 LDR instruction held, S toggled 0->1 -> ID_* all 0 immediately; EX_* all 0 after next edge; MEM_* all 0 after second edge.
REQ-027 Pipeline filled with LDR, R driven low between edges -> EX_* and MEM_* (and WB_RF_enable if enabled) read 0 before the next clk edge; ID_* unchanged.
REQ-028 instruction=0x00000000 and 0xE0010392 (MUL) -> all ID_* 0.

Source files
------------

// File: rtl/cu_pipe_ctrl_if.sv
// cu_pipe_ctrl_if: instruction/bubble inputs and ID/EX/MEM control outputs of the pipeline control unit.
// WB_RF_enable exists only when CU_PIPE_WB_STAGE_EN is defined.
interface cu_pipe_ctrl_if;
    logic [31:0] instruction;
    logic        S;
    logic [3:0]  ID_opcode;
    logic        ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable;
    logic        ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr;
    logic [3:0]  EX_opcode;
    logic        EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable;
    logic        EX_RW_enable, EX_Enable_signal;
    logic        MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal;
`ifdef CU_PIPE_WB_STAGE_EN
    logic        WB_RF_enable;
`endif
    modport master (
        output instruction, S,
        input  ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable,
               ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr,
               EX_opcode, EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable,
               EX_RW_enable, EX_Enable_signal,
               MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal
`ifdef CU_PIPE_WB_STAGE_EN
             , WB_RF_enable
`endif
    );
    modport slave (
        input  instruction, S,
        output ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable,
               ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr,
               EX_opcode, EX_AM, EX_S_enable, EX_load_instr, EX_RF_enable, EX_Size_enable,
               EX_RW_enable, EX_Enable_signal,
               MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal
`ifdef CU_PIPE_WB_STAGE_EN
             , WB_RF_enable
`endif
    );
endinterface

// File: rtl/cu_pipe_ctrl.sv
// cu_pipe_ctrl: ARM-style control decoder with bubble mux and ID/EX, EX/MEM control registers.
// Optional WB stage register for RF enable under CU_PIPE_WB_STAGE_EN.
module cu_pipe_ctrl (
    input  logic          clk,
    input  logic          R,
    cu_pipe_ctrl_if.slave bus
);
    typedef struct packed {
        logic [3:0] opcode;
        logic       am, s_en, load, rf, size, rw, en, bl, b;
    } ctrl_t;

    ctrl_t       dec, id;
    logic [31:0] ins;
    logic [10:0] ex_d, ex_q;
    logic [4:0]  mem_d, mem_q;

    assign ins = bus.instruction;

    always_comb begin
        dec = '0;
        if (ins != 32'h0) begin
            // [27:25]=000 with [7]&[4] is the multiply/extra-load space, left undecoded
            if (ins[27:26] == 2'b00 && !(ins[25] == 1'b0 && ins[7] && ins[4])) begin
                dec.opcode = ins[24:21];
                dec.s_en   = ins[20];
                dec.am     = ins[25];
                dec.rf     = ins[24:23] != 2'b10;
            end else if (ins[27:26] == 2'b01) begin
                dec.en     = 1'b1;
                dec.load   = ins[20];
                dec.rf     = ins[20];
                dec.rw     = ~ins[20];
                dec.size   = ins[22];
                dec.opcode = ins[23] ? 4'b0100 : 4'b0010;
                dec.am     = ~ins[25];
            end else if (ins[27:25] == 3'b101) begin
                dec.b      = 1'b1;
                dec.bl     = ins[24];
                dec.rf     = ins[24];
            end
        end
        id    = bus.S ? '0 : dec;
        ex_d  = id[12:2];
        mem_d = ex_q[4:0];
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    assign {bus.ID_opcode, bus.ID_AM, bus.ID_S_enable, bus.ID_load_instr, bus.ID_RF_enable,
            bus.ID_Size_enable, bus.ID_RW_enable, bus.ID_Enable_signal, bus.ID_BL_instr,
            bus.ID_B_instr} = id;
    assign {bus.EX_opcode, bus.EX_AM, bus.EX_S_enable, bus.EX_load_instr, bus.EX_RF_enable,
            bus.EX_Size_enable, bus.EX_RW_enable, bus.EX_Enable_signal} = ex_q;
    assign {bus.MEM_load_instr, bus.MEM_RF_enable, bus.MEM_Size_enable, bus.MEM_RW_enable,
            bus.MEM_Enable_signal} = mem_q;

`ifdef CU_PIPE_WB_STAGE_EN
    logic wb_d, wb_q;
    assign wb_d = mem_q[3];
    always_ff @(posedge clk or negedge R) begin
        if (!R) wb_q <= 1'b0;
        else    wb_q <= wb_d;
    end
    assign bus.WB_RF_enable = wb_q;
`endif
endmodule

// File: tb/tb_cu_pipe_ctrl.sv
// tb_cu_pipe_ctrl: directed checks of decode, bubble mux, pipeline latency and async reset.
// Vectors pack ID as {opcode,AM,S,load,RF,Size,RW,En,BL,B}.
module tb_cu_pipe_ctrl;
    logic clk = 1'b0;
    logic R   = 1'b0;
    int   checks = 0;
    int   failures = 0;

    cu_pipe_ctrl_if bus ();
    cu_pipe_ctrl dut (.clk(clk), .R(R), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [12:0] E_ADDS = 13'b0100_1_1_0_1_0_0_0_0_0;
    localparam logic [12:0] E_LDR  = 13'b0100_1_0_1_1_0_0_1_0_0;
    localparam logic [12:0] E_STRB = 13'b0010_1_0_0_0_1_1_1_0_0;
    localparam logic [12:0] E_BL   = 13'b0000_0_0_0_1_0_0_0_1_1;
    localparam logic [12:0] E_B    = 13'b0000_0_0_0_0_0_0_0_0_1;
    localparam logic [12:0] E_CMP  = 13'b1010_1_1_0_0_0_0_0_0_0;
    localparam logic [12:0] E_ADD  = 13'b0100_0_0_0_1_0_0_0_0_0;

    logic [12:0] id_v;
    logic [10:0] ex_v;
    logic [4:0]  mem_v;
    assign id_v  = {bus.ID_opcode, bus.ID_AM, bus.ID_S_enable, bus.ID_load_instr, bus.ID_RF_enable,
                    bus.ID_Size_enable, bus.ID_RW_enable, bus.ID_Enable_signal, bus.ID_BL_instr,
                    bus.ID_B_instr};
    assign ex_v  = {bus.EX_opcode, bus.EX_AM, bus.EX_S_enable, bus.EX_load_instr, bus.EX_RF_enable,
                    bus.EX_Size_enable, bus.EX_RW_enable, bus.EX_Enable_signal};
    assign mem_v = {bus.MEM_load_instr, bus.MEM_RF_enable, bus.MEM_Size_enable, bus.MEM_RW_enable,
                    bus.MEM_Enable_signal};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] ex_of(input logic [12:0] v);
        return v[12:2];
    endfunction

    function automatic logic [4:0] mem_of(input logic [12:0] v);
        return v[6:2];
    endfunction

    logic [31:0] vin [8] = '{32'hE5410001, 32'hEB000004, 32'hEA000004, 32'hE3510000,
                             32'hE0812003, 32'hE0010392, 32'h00000000, 32'hEF000000};
    logic [12:0] vexp [8] = '{E_STRB, E_BL, E_B, E_CMP, E_ADD, 13'h0, 13'h0, 13'h0};

    initial begin
        bus.instruction = 32'hE2921005;
        bus.S = 1'b0;
        #3;
        chk("reset_id_adds", 16'(id_v), 16'(E_ADDS));
        chk("reset_ex", 16'(ex_v), 16'h0);
        chk("reset_mem", 16'(mem_v), 16'h0);
        @(negedge clk);
        R = 1'b1;
        step();
        chk("adds_ex", 16'(ex_v), 16'(ex_of(E_ADDS)));
        chk("adds_mem_empty", 16'(mem_v), 16'h0);
        bus.instruction = 32'hE5910004;
        #1;
        chk("ldr_id", 16'(id_v), 16'(E_LDR));
        step();
        chk("ldr_ex", 16'(ex_v), 16'(ex_of(E_LDR)));
        chk("adds_mem", 16'(mem_v), 16'(mem_of(E_ADDS)));
        chk("adds_mem_rf", 16'(bus.MEM_RF_enable), 16'h1);
        step();
        chk("ldr_mem", 16'(mem_v), 16'(mem_of(E_LDR)));
`ifdef CU_PIPE_WB_STAGE_EN
        step();
        chk("ldr_wb", 16'(bus.WB_RF_enable), 16'h1);
`endif
        bus.S = 1'b1;
        #1;
        chk("bubble_id", 16'(id_v), 16'h0);
        chk("bubble_ex_hold", 16'(ex_v), 16'(ex_of(E_LDR)));
        step();
        chk("bubble_ex", 16'(ex_v), 16'h0);
        chk("bubble_mem_hold", 16'(mem_v), 16'(mem_of(E_LDR)));
        step();
        chk("bubble_mem", 16'(mem_v), 16'h0);
        bus.S = 1'b0;
        step();
        step();
        step();
        chk("refill_mem", 16'(mem_v), 16'(mem_of(E_LDR)));
        #2;
        R = 1'b0;
        #1;
        chk("async_ex", 16'(ex_v), 16'h0);
        chk("async_mem", 16'(mem_v), 16'h0);
        chk("async_id", 16'(id_v), 16'(E_LDR));
`ifdef CU_PIPE_WB_STAGE_EN
        chk("async_wb", 16'(bus.WB_RF_enable), 16'h0);
`endif
        @(negedge clk);
        R = 1'b1;
        step();
        chk("post_reset_ex", 16'(ex_v), 16'(ex_of(E_LDR)));
        chk("post_reset_mem", 16'(mem_v), 16'h0);
        for (int i = 0; i < 8; i++) begin
            bus.instruction = vin[i];
            #1;
            chk($sformatf("dec_%08h", vin[i]), 16'(id_v), 16'(vexp[i]));
        end
        bus.instruction = 32'hEB000004;
        step();
        chk("bl_ex_drops_branch", 16'(ex_v), 16'(ex_of(E_BL)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
